// File: rtl/neuraedge_tile_pkg.sv
// Shared types and constants for the neuraedge tile bank arbiter.
package neuraedge_tile_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } bank_state_e;

  localparam int NUM_REQ_DEF = 3;
  localparam int BANKS_DEF   = 4;

  localparam int BANK_IDX_W = $clog2(BANKS_DEF);
  localparam int REQ_ID_W   = $clog2(NUM_REQ_DEF);

  localparam int REQ_CTRL = 0;
  localparam int REQ_NOC  = 1;
  localparam int REQ_PE   = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over NUM_REQ eligibility bits starting at ptr_i.
// Optional macro TILE_ARB_PRIO0_EN: requester 0 always wins when eligible,
// and the pointer only advances on grants to the other requesters.
module rr_arbiter
  import neuraedge_tile_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int RIW     = REQ_ID_W
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [RIW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [RIW-1:0]     grant_id_o,
  output logic               grant_valid_o,
  output logic [RIW-1:0]     ptr_next_o
);

  // First eligible requester at or after the pointer, wrapping; then pointer update.
  always_comb begin
    int          idx;
    logic        found;
    logic [RIW-1:0] id;
    logic        advance;
    idx     = 0;
    found   = 1'b0;
    id      = '0;
    advance = 1'b0;
    grant_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && elig_i[idx]) begin
        found = 1'b1;
        id    = RIW'(idx);
      end
    end
`ifdef TILE_ARB_PRIO0_EN
    if (elig_i[REQ_CTRL]) begin
      found = 1'b1;
      id    = RIW'(REQ_CTRL);
    end
    advance = found && (id != RIW'(REQ_CTRL));
`else
    advance = found;
`endif
    if (found) grant_o[id] = 1'b1;
    grant_id_o    = id;
    grant_valid_o = found;
    if (advance)
      ptr_next_o = (int'(id) + 1 >= NUM_REQ) ? '0 : id + 1'b1;
    else
      ptr_next_o = ptr_i;
  end

endmodule

// File: rtl/tile_bank_arbiter.sv
// Per-bank round-robin arbitration of the tile scratchpad between requesters.
// Each bank holds one transaction in a two-state FSM until bank_ready, then the
// completion pulses back to the owning requester one cycle later.
// Optional macro TILE_ARB_PRIO0_EN gives requester 0 fixed priority.
module tile_bank_arbiter
  import neuraedge_tile_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int BANKS   = BANKS_DEF,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*((BANKS>1)?$clog2(BANKS):1)-1:0] req_bank,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0]  rsp_rdata,
  output logic [BANKS-1:0]           bank_enable,
  output logic [BANKS-1:0]           bank_write_en,
  output logic [BANKS*ADDR_W-1:0]    bank_addr,
  output logic [BANKS*DATA_W-1:0]    bank_wdata,
  input  logic [BANKS*DATA_W-1:0]    bank_rdata,
  input  logic [BANKS-1:0]           bank_ready
);

  localparam int BIW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int RIW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Unflattened request / bank-data views
  logic [BIW-1:0]    req_bank_a  [NUM_REQ];
  logic [ADDR_W-1:0] req_addr_a  [NUM_REQ];
  logic [DATA_W-1:0] req_wdata_a [NUM_REQ];
  logic [DATA_W-1:0] bank_rdata_a[BANKS];

  // Requester-side state
  logic [NUM_REQ-1:0] out_q, out_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q [NUM_REQ];
  logic [DATA_W-1:0]  rsp_rdata_d [NUM_REQ];

  // Bank-side state
  bank_state_e       state_q [BANKS];
  bank_state_e       state_d [BANKS];
  logic [RIW-1:0]    ptr_q   [BANKS];
  logic              we_q    [BANKS];
  logic [ADDR_W-1:0] addr_q  [BANKS];
  logic [DATA_W-1:0] wdata_q [BANKS];
  logic [RIW-1:0]    owner_q [BANKS];

  // Arbiter results
  logic [NUM_REQ-1:0] gnt       [BANKS];
  logic [RIW-1:0]     gnt_id    [BANKS];
  logic               gnt_valid [BANKS];
  logic [RIW-1:0]     ptr_nxt   [BANKS];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_bank_a[gi]  = req_bank[gi*BIW +: BIW];
    assign req_addr_a[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign req_wdata_a[gi] = req_wdata[gi*DATA_W +: DATA_W];
    assign rsp_rdata[gi*DATA_W +: DATA_W] = rsp_rdata_q[gi];
  end

  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    logic [NUM_REQ-1:0] elig;

    // A requester is eligible when it targets this idle bank and has nothing in flight
    // (a response going out this cycle frees it immediately).
    always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        elig[i] = rst_n && (state_q[gi] == S_IDLE) && req_valid[i] &&
                  (req_bank_a[i] == BIW'(gi)) && (!out_q[i] || rsp_valid_q[i]);
      end
    end

    rr_arbiter #(
      .NUM_REQ(NUM_REQ),
      .RIW    (RIW)
    ) u_rr (
      .elig_i       (elig),
      .ptr_i        (ptr_q[gi]),
      .grant_o      (gnt[gi]),
      .grant_id_o   (gnt_id[gi]),
      .grant_valid_o(gnt_valid[gi]),
      .ptr_next_o   (ptr_nxt[gi])
    );

    assign bank_rdata_a[gi] = bank_rdata[gi*DATA_W +: DATA_W];
    assign bank_enable[gi]   = (state_q[gi] == S_BUSY);
    assign bank_write_en[gi] = (state_q[gi] == S_BUSY) && we_q[gi];
    assign bank_addr[gi*ADDR_W +: ADDR_W]  = (state_q[gi] == S_BUSY) ? addr_q[gi]  : '0;
    assign bank_wdata[gi*DATA_W +: DATA_W] = (state_q[gi] == S_BUSY) ? wdata_q[gi] : '0;
  end

  // Merge per-bank grants into the per-requester ready vector.
  always_comb begin
    req_ready = '0;
    for (int b = 0; b < BANKS; b++) req_ready = req_ready | gnt[b];
  end

  // Bank FSM next state: grant moves to BUSY, bank_ready returns to IDLE.
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      state_d[b] = state_q[b];
      case (state_q[b])
        S_IDLE:  if (gnt_valid[b])  state_d[b] = S_BUSY;
        S_BUSY:  if (bank_ready[b]) state_d[b] = S_IDLE;
        default: state_d[b] = S_IDLE;
      endcase
    end
  end

  // Completing banks produce next cycle's response for their owner; writes return zero.
  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) rsp_rdata_d[i] = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (state_q[b] == S_BUSY && bank_ready[b]) begin
        rsp_valid_d[owner_q[b]] = 1'b1;
        rsp_rdata_d[owner_q[b]] = we_q[b] ? '0 : bank_rdata_a[b];
      end
    end
  end

  assign out_d     = (out_q & ~rsp_valid_q) | req_ready;
  assign rsp_valid = rsp_valid_q;

  // Bank FSM state, round-robin pointer and captured transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        state_q[b] <= S_IDLE;
        ptr_q[b]   <= '0;
        we_q[b]    <= 1'b0;
        addr_q[b]  <= '0;
        wdata_q[b] <= '0;
        owner_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        state_q[b] <= state_d[b];
        if (state_q[b] == S_IDLE && gnt_valid[b]) begin
          ptr_q[b]   <= ptr_nxt[b];
          we_q[b]    <= req_we[gnt_id[b]];
          addr_q[b]  <= req_addr_a[gnt_id[b]];
          wdata_q[b] <= req_wdata_a[gnt_id[b]];
          owner_q[b] <= gnt_id[b];
        end
      end
    end
  end

  // Outstanding flags and the registered completion pulse per requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      rsp_valid_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) rsp_rdata_q[i] <= '0;
    end else begin
      out_q       <= out_d;
      rsp_valid_q <= rsp_valid_d;
      for (int i = 0; i < NUM_REQ; i++) rsp_rdata_q[i] <= rsp_rdata_d[i];
    end
  end

endmodule

// File: doc/tile_bank_arbiter.md
Name: tile_bank_arbiter

Overview:
Shares the tile's four-bank scratchpad (tile_memory bank port) between several requesters: tile controller, NoC memory-command path and PE writeback.
Each bank has its own round-robin arbiter and a small per-bank FSM that holds one transaction until the bank signals ready.
Completions route back to the owning requester.
Sits between tile_controller/NoC ingress and tile_memory inside neuraedge_tile.

Parameters:
NUM_REQ, 3, number of requesters (0 = controller, 1 = NoC, 2 = PE writeback)
BANKS, 4, number of memory banks; must be a power of 2
ADDR_W, 13, per-bank word address width
DATA_W, 64, data width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  request accepted this cycle
req_we  in  NUM_REQ  1 = write, 0 = read
req_bank  in  NUM_REQ*log2(BANKS)  target bank, flattened
req_addr  in  NUM_REQ*ADDR_W  word address, flattened
req_wdata  in  NUM_REQ*DATA_W  write data, flattened
rsp_valid  out  NUM_REQ  one-cycle completion pulse
rsp_rdata  out  NUM_REQ*DATA_W  read data; zero for write completions
bank_enable  out  BANKS  bank access active
bank_write_en  out  BANKS  bank write strobe
bank_addr  out  BANKS*ADDR_W  bank address, flattened
bank_wdata  out  BANKS*DATA_W  bank write data, flattened
bank_rdata  in  BANKS*DATA_W  bank read data
bank_ready  in  BANKS  bank completes the access this cycle

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: every output is 0. All bank FSMs go to IDLE. RR pointers and outstanding flags are 0.
- Outstanding rule: each requester has at most one transaction in flight.
  - Its outstanding flag sets on acceptance.
  - The flag clears in the cycle its rsp_valid is driven.
  - A new acceptance is allowed in that same cycle.
- Eligibility: requester i is eligible for bank b when req_valid[i], req_bank[i]==b, and its outstanding flag is clear (or is clearing this cycle).
- Per-bank FSM, states IDLE and BUSY:
  - IDLE with at least one eligible requester:
    - Grant goes to the first eligible requester at or after ptr[b], wrapping modulo NUM_REQ.
    - req_ready[winner]=1 combinationally in the same cycle (T).
    - we/addr/wdata/owner are registered.
    - ptr[b] becomes winner+1 mod NUM_REQ.
    - Next state is BUSY.
  - BUSY:
    - bank_enable[b]=1; bank_write_en[b]=captured we; addr and wdata held stable from T+1.
    - They stay stable until bank_ready[b] is sampled 1.
    - In that cycle bank_rdata is captured, and the FSM returns to IDLE on the next edge.
  - Response: rsp_valid[owner]=1 for exactly one cycle after the bank_ready cycle. rsp_rdata carries captured data for reads and 0 for writes.
  - Minimum latency: accept T, bank access T+1, rsp T+2. The bank can re-grant at T+2.
- Concurrency:
  - Different banks grant independently in the same cycle.
  - A requester targets one bank, so it is never double-granted.
  - Responses cannot collide because of the outstanding rule.
- req_ready is never 1 without req_valid. A requester not granted sees req_ready=0 and must hold its request stable.
- bank_ready while IDLE is ignored.
- Reset mid-BUSY: the next edge returns all state and outputs to reset values. The in-flight response is dropped.

Optional Feature:
TILE_ARB_PRIO0_EN:
- Defined: requester 0 (controller) always wins any bank it is eligible for. The RR pointer advances only on grants to other requesters.
- Undefined: pure round-robin for all requesters.

Decomposition:
- Package neuraedge_tile_pkg holds:
  - the bank FSM state enum (IDLE/BUSY);
  - BANK_IDX_W and REQ_ID_W as clog2 constants;
  - requester ID constants REQ_CTRL=0, REQ_NOC=1, REQ_PE=2.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin pick given an eligibility vector and a pointer. It is instantiated once per bank in a generate loop. The optional priority override lives inside it.

Test Plan:
1. Requester 0 reads bank 2, addr 0x0123; bank_ready[2]=1 at T+1 with rdata 0xDEADBEEF_CAFEF00D -> req_ready[0] at T, bank_enable[2] at T+1, rsp_valid[0] at T+2 with that data.
2. Requesters 0, 1, 2 all target bank 1 at T; bank_ready is immediate -> grants 0 at T, 1 at T+2, 2 at T+4, then ptr=0. With TILE_ARB_PRIO0_EN and requester 0 re-requesting every time, requester 0 wins each grant.
3. Requester 0 to bank 0 and requester 1 to bank 3 at T -> both req_ready at T, both bank_enable at T+1.
4. Requester 1 writes bank 0, wdata 0x1122334455667788; bank_ready held low 5 cycles -> bank_enable, write_en, addr, wdata stable for 6 cycles; requester 2 requests to bank 0 see req_ready=0 throughout; rsp_valid[1] has rsp_rdata=0.
5. Requester 0 is accepted for bank 0 at T and keeps req_valid for bank 1 -> req_ready[0]=0 until its rsp cycle, then accepted in that same cycle.
6. rst_n=0 while bank 2 is BUSY -> all outputs 0 the next cycle, no rsp_valid; requests after reset are granted starting from requester 0.
